serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx.sv | 117 +++++++++++
 tb/tb_serial_frame_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit (0), WIDTH data bits LSB first,
// stop bit (1), each bit held for BIT_CYCLES clocks. Every output is a flop.
module serial_frame_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             ready,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, shreg_shift;
  logic [BW-1:0]    bit_idx, bit_idx_n;
  logic [CW-1:0]    cyc_cnt, cyc_cnt_n;
  logic             serial_n, ready_n, busy_n, done_n;
  logic             bit_end;

  assign bit_end     = (cyc_cnt == CYC_LAST);
  assign shreg_shift = shreg >> 1;

  // Outputs are computed for the next cycle so the line changes exactly on bit boundaries.
  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    cyc_cnt_n = bit_end ? '0 : cyc_cnt + 1'b1;
    serial_n  = 1'b1;
    ready_n   = 1'b0;
    busy_n    = 1'b1;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        cyc_cnt_n = '0;
        bit_idx_n = '0;
        busy_n    = 1'b0;
        ready_n   = 1'b1;
        if (start) begin
          state_n  = START;
          shreg_n  = data_in;
          serial_n = 1'b0;
          busy_n   = 1'b1;
          ready_n  = 1'b0;
        end
      end
      START: begin
        serial_n = 1'b0;
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          serial_n  = shreg[0];
        end
      end
      DATA: begin
        serial_n = shreg[0];
        if (bit_end) begin
          shreg_n = shreg_shift;
          if (bit_idx == BIT_LAST) begin
            state_n  = STOP;
            serial_n = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 1'b1;
            serial_n  = shreg_shift[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          ready_n = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
        ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      cyc_cnt    <= '0;
      serial_out <= 1'b1;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_idx    <= bit_idx_n;
      cyc_cnt    <= cyc_cnt_n;
      serial_out <= serial_n;
      ready      <= ready_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: an 8-bit/4-cycle instance and a 4-bit/1-cycle instance.
// Stimulus pushes expected line patterns; per-instance monitors rebuild frames and compare on done.
module tb_serial_frame_tx;

  typedef struct {
    logic [63:0] bits;
    int          len;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0;
  logic [7:0] data0 = '0;
  logic       ready0, serial0, busy0, done0;
  logic       start1 = 1'b0;
  logic [3:0] data1 = '0;
  logic       ready1, serial1, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  frame_t q0[$];
  frame_t q1[$];

  always #5 clk = ~clk;

  serial_frame_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .data_in(data0),
    .ready(ready0), .serial_out(serial0), .busy(busy0), .done(done0)
  );

  serial_frame_tx #(.WIDTH(4), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .data_in(data1),
    .ready(ready1), .serial_out(serial1), .busy(busy1), .done(done1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line, one bit per clock: start, data LSB first, stop.
  function automatic frame_t frame_model(input logic [7:0] d, input int w, input int bc);
    frame_t f;
    f.bits = '0;
    f.len  = (2 + w) * bc;
    for (int t = 0; t < f.len; t++) begin
      int b;
      b = t / bc;
      if (b == 0)      f.bits[t] = 1'b0;
      else if (b <= w) f.bits[t] = d[b-1];
      else             f.bits[t] = 1'b1;
    end
    return f;
  endfunction

  logic [63:0] acc0 = '0, acc1 = '0;
  int          n0 = 0, n1 = 0;
  int          done_cnt0 = 0, done_cnt1 = 0;
  frame_t      f0, f1;

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      done_cnt0++;
      check("dut0_frame_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) begin
        f0 = q0.pop_front();
        check("dut0_frame_len", 64'(n0), 64'(f0.len));
        check("dut0_frame_bits", acc0, f0.bits);
      end
      acc0 = '0;
      n0   = 0;
    end else if (busy0 === 1'b1) begin
      if (n0 < 64) acc0[n0] = serial0;
      n0++;
    end else begin
      acc0 = '0;
      n0   = 0;
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      done_cnt1++;
      check("dut1_frame_expected", 64'(q1.size() != 0), 64'd1);
      if (q1.size() != 0) begin
        f1 = q1.pop_front();
        check("dut1_frame_len", 64'(n1), 64'(f1.len));
        check("dut1_frame_bits", acc1, f1.bits);
      end
      acc1 = '0;
      n1   = 0;
    end else if (busy1 === 1'b1) begin
      if (n1 < 64) acc1[n1] = serial1;
      n1++;
    end else begin
      acc1 = '0;
      n1   = 0;
    end
  end

  task automatic send0(input logic [7:0] d);
    start0 = 1'b1;
    data0  = d;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  task automatic wait_done0(input int maxc, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] a5_line;
    logic [6:0] dut1_line;
    int         dc;
    a5_line   = 10'b1_10100101_0;
    dut1_line = 7'b1110010;

    // Reset and quiet idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      check("rst_serial", 64'(serial0), 64'd1);
      check("rst_ready",  64'(ready0),  64'd1);
      check("rst_busy",   64'(busy0),   64'd0);
      check("rst_done",   64'(done0),   64'd0);
    end

    // Single frame 8'hA5: line pattern, ready low and done timing
    q0.push_back(frame_model(8'hA5, 8, 4));
    send0(8'hA5);
    for (int j = 0; j <= 40; j++) begin
      @(negedge clk);
      if (j < 40) begin
        check("a5_line",  64'(serial0), 64'(a5_line[j/4]));
        check("a5_ready", 64'(ready0),  64'd0);
        check("a5_done",  64'(done0),   64'd0);
      end else begin
        check("a5_done_k40",  64'(done0),  64'd1);
        check("a5_ready_k40", 64'(ready0), 64'd1);
      end
    end

    // Start while busy is ignored
    q0.push_back(frame_model(8'h0F, 8, 4));
    send0(8'h0F);
    repeat (11) @(posedge clk);
    #1 start0 = 1'b1;
    data0 = 8'hFF;
    @(posedge clk);
    #1 start0 = 1'b0;
    wait_done0(40, "busy_reject_done");

    // Back-to-back: second start taken in the done cycle
    q0.push_back(frame_model(8'h01, 8, 4));
    q0.push_back(frame_model(8'h80, 8, 4));
    send0(8'h01);
    repeat (40) @(posedge clk);
    #1 check("b2b_done_first", 64'(done0), 64'd1);
    start0 = 1'b1;
    data0  = 8'h80;
    @(posedge clk);
    #1 start0 = 1'b0;
    check("b2b_start_bit", 64'(serial0), 64'd0);
    check("b2b_busy",      64'(busy0),   64'd1);
    wait_done0(45, "b2b_done_second");

    // Reset mid-frame abandons 8'h3C without a done pulse
    send0(8'h3C);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("midrst_serial", 64'(serial0), 64'd1);
    check("midrst_ready",  64'(ready0),  64'd1);
    check("midrst_busy",   64'(busy0),   64'd0);
    check("midrst_done",   64'(done0),   64'd0);
    dc = done_cnt0;
    repeat (45) @(negedge clk);
    check("midrst_no_done", 64'(done_cnt0 - dc), 64'd0);
    q0.push_back(frame_model(8'hC3, 8, 4));
    @(posedge clk);
    #1 send0(8'hC3);
    wait_done0(45, "after_rst_done");

    // One-cycle bits, 4-bit word 4'b1001
    q1.push_back('{bits: 64'b110010, len: 6});
    start1 = 1'b1;
    data1  = 4'b1001;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      check("bc1_line", 64'(serial1), 64'(dut1_line[j]));
      check("bc1_done", 64'(done1),   64'(j == 6));
    end

    repeat (3) @(negedge clk);
    check("dut0_queue_drained", 64'(q0.size()), 64'd0);
    check("dut1_queue_drained", 64'(q1.size()), 64'd0);
    check("dut0_done_count",    64'(done_cnt0), 64'd5);
    check("dut1_done_count",    64'(done_cnt1), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
